fpga_config_loader: RTL and testbench

- Synthesizable configuration sequencer for the `fpga` fabric.
- Accepts bitstream frames over a valid/ready stream and writes each frame into the fabric by driving `configs_in` with a one-hot `configs_en` strobe.
- After the last frame and a settle delay it enables the fabric flip-flops (`ff_en`), then asserts `rdy`.
- Sits between a bitstream source (memory/DMA/host) and the `fpga` instance; replaces the simulation-only file loader in the per-design wrappers.

---
 rtl/fpga_cfg_pkg.sv | 35 +++
 rtl/fpga_cfg_delay.sv | 30 +++
 rtl/fpga_config_loader.sv | 162 ++++++++++++++++
 tb/tb_fpga_config_loader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared types and helpers for the fabric configuration loader.
// Frame strobes are built from a wide one-hot vector and narrowed at the use site.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_SETTLE,
        ST_ARM,
        ST_RUN
    } cfg_state_t;

    localparam int DEF_WORD_W        = 320;
    localparam int DEF_NUM_FRAMES    = 172;
    localparam int DEF_SETTLE_CYCLES = 10;
    localparam int DEF_RDY_DELAY     = 10;

    // Upper bound on frame count supported by onehot_frame.
    localparam int MAX_FRAMES = 1024;
    localparam int MAX_IDX_W  = $clog2(MAX_FRAMES);

    function automatic logic [MAX_FRAMES-1:0] onehot_frame(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_FRAMES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // A delay of N cycles reloads the down-counter with N-1; zero still costs one cycle.
    function automatic int delay_load(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/fpga_cfg_delay.sv
// Loadable down-counter shared by the SETTLE and ARM waits.
// done is high while the count sits at zero.
module fpga_cfg_delay
    import fpga_cfg_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/fpga_config_loader.sv
// Streams configuration frames into the fabric one strobe at a time, then
// waits out the settle and arm delays before releasing the fabric flip-flops.
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int WORD_W        = DEF_WORD_W,
    parameter int NUM_FRAMES    = DEF_NUM_FRAMES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int RDY_DELAY     = DEF_RDY_DELAY,
    localparam int IDX_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cfg_valid,
    input  logic [WORD_W-1:0]     cfg_data,
    output logic                  cfg_ready,
    output logic [WORD_W-1:0]     configs_in,
    output logic [NUM_FRAMES-1:0] configs_en,
    output logic                  ff_en,
    output logic                  rdy,
    output logic                  busy,
    output logic [IDX_W-1:0]      frame_idx
);

    localparam int DLY_MAX = (SETTLE_CYCLES > RDY_DELAY) ? SETTLE_CYCLES : RDY_DELAY;
    localparam int CNT_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(delay_load(SETTLE_CYCLES));
    localparam logic [CNT_W-1:0] ARM_LOAD    = CNT_W'(delay_load(RDY_DELAY));
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_FRAMES - 1);

    cfg_state_t            state_q, state_d;
    logic                  ready_q, ready_d;
    logic [WORD_W-1:0]     cfg_in_d;
    logic [NUM_FRAMES-1:0] en_d;
    logic                  ff_en_d, rdy_d, busy_d;
    logic [IDX_W-1:0]      idx_d;
    logic                  dly_load, dly_dec, dly_done;
    logic [CNT_W-1:0]      dly_val;
    logic                  accept;

    // abort masks the handshake so a word offered alongside it is never consumed
    assign cfg_ready = ready_q & ~abort;
    assign accept    = cfg_valid & cfg_ready;

    fpga_cfg_delay #(
        .CNT_W(CNT_W)
    ) u_delay (
        .clock   (clock),
        .rst     (rst),
        .load    (dly_load),
        .load_val(dly_val),
        .dec     (dly_dec),
        .done    (dly_done)
    );

    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        cfg_in_d = configs_in;
        en_d     = '0;
        ff_en_d  = ff_en;
        rdy_d    = rdy;
        idx_d    = frame_idx;
        dly_load = 1'b0;
        dly_val  = SETTLE_LOAD;
        dly_dec  = 1'b0;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            ff_en_d = 1'b0;
            rdy_d   = 1'b0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_LOAD;
                        ready_d = 1'b1;
                        idx_d   = '0;
                    end
                end
                ST_LOAD: begin
                    ready_d = 1'b1;
                    if (accept) begin
                        state_d  = ST_WRITE;
                        ready_d  = 1'b0;
                        cfg_in_d = cfg_data;
                        en_d     = NUM_FRAMES'(onehot_frame(MAX_IDX_W'(frame_idx)));
                    end
                end
                ST_WRITE: begin
                    if (frame_idx == LAST_IDX) begin
                        state_d  = ST_SETTLE;
                        idx_d    = '0;
                        dly_load = 1'b1;
                        dly_val  = SETTLE_LOAD;
                    end else begin
                        state_d = ST_LOAD;
                        ready_d = 1'b1;
                        idx_d   = frame_idx + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (dly_done) begin
                        state_d  = ST_ARM;
                        ff_en_d  = 1'b1;
                        dly_load = 1'b1;
                        dly_val  = ARM_LOAD;
                    end else begin
                        dly_dec = 1'b1;
                    end
                end
                ST_ARM: begin
                    if (dly_done) begin
                        state_d = ST_RUN;
                        rdy_d   = 1'b1;
                    end else begin
                        dly_dec = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        state_d = ST_LOAD;
                        ready_d = 1'b1;
                        ff_en_d = 1'b0;
                        rdy_d   = 1'b0;
                        idx_d   = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = state_d inside {ST_LOAD, ST_WRITE, ST_SETTLE, ST_ARM};
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            configs_in <= '0;
            configs_en <= '0;
            ff_en      <= 1'b0;
            rdy        <= 1'b0;
            busy       <= 1'b0;
            frame_idx  <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            configs_in <= cfg_in_d;
            configs_en <= en_d;
            ff_en      <= ff_en_d;
            rdy        <= rdy_d;
            busy       <= busy_d;
            frame_idx  <= idx_d;
        end
    end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Randomised scoreboard bench for the configuration loader: a small 8x4 instance
// for protocol corners and a default-sized instance for a full-length load.
module tb_fpga_config_loader;

    localparam int W     = 8;
    localparam int N     = 4;
    localparam int S     = 3;
    localparam int R     = 2;
    localparam int S_EFF = (S > 0) ? S : 1;
    localparam int R_EFF = (R > 0) ? R : 1;
    localparam int BW    = 320;
    localparam int BN    = 172;
    localparam int CW    = 320;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    logic         start = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
    logic [W-1:0] cfg_data = '0;
    logic         cfg_ready, ff_en, rdy, busy;
    logic [W-1:0] configs_in;
    logic [N-1:0] configs_en;
    logic [1:0]   frame_idx;

    logic          b_start = 1'b0, b_abort = 1'b0, b_valid = 1'b0;
    logic [BW-1:0] b_data = '0;
    logic          b_ready, b_ff_en, b_rdy, b_busy;
    logic [BW-1:0] b_configs_in;
    logic [BN-1:0] b_en;
    logic [7:0]    b_idx;

    always #5 clock = ~clock;

    fpga_config_loader #(.WORD_W(W), .NUM_FRAMES(N), .SETTLE_CYCLES(S), .RDY_DELAY(R)) dut (
        .clock(clock), .rst(rst), .start(start), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .configs_in(configs_in), .configs_en(configs_en), .ff_en(ff_en),
        .rdy(rdy), .busy(busy), .frame_idx(frame_idx)
    );

    fpga_config_loader #(.WORD_W(BW), .NUM_FRAMES(BN), .SETTLE_CYCLES(10), .RDY_DELAY(10)) dut_big (
        .clock(clock), .rst(rst), .start(b_start), .abort(b_abort),
        .cfg_valid(b_valid), .cfg_data(b_data), .cfg_ready(b_ready),
        .configs_in(b_configs_in), .configs_en(b_en), .ff_en(b_ff_en),
        .rdy(b_rdy), .busy(b_busy), .frame_idx(b_idx)
    );

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   b2b_mode = 1'b0;

    logic [BW-1:0] b_words [BN];
    int            b_next = 0;

    task automatic checkOutput(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference timeline: each strobe pops the next expected frame; the last one
    // schedules the ff_en and rdy rising cycles from the configured delays.
    logic [N-1:0] prev_en   = '0;
    logic [W-1:0] prev_data = '0;
    logic         prev_ff   = 1'b0, prev_rdy = 1'b0;
    bit           ff_pend   = 1'b0, rdy_pend = 1'b0;
    int           ff_due    = 0, rdy_due = 0, last_strobe = 0;

    always @(negedge clock) begin
        exp_t         e;
        logic [N-1:0] exp_en;
        cyc++;
        if (!rst) begin
            if (configs_en != '0) begin
                checkOutput("strobe_onehot", CW'($onehot(configs_en)), CW'(1));
                checkOutput("ready_in_write", CW'(cfg_ready), CW'(0));
                checkOutput("strobe_spacing", CW'(prev_en), CW'(0));
                if (exp_q.size() == 0) begin
                    failNow("unexpected_strobe");
                end else begin
                    e = exp_q.pop_front();
                    exp_en = '0;
                    exp_en[e.idx] = 1'b1;
                    checkOutput("strobe_pos", CW'(configs_en), CW'(exp_en));
                    checkOutput("strobe_data", CW'(configs_in), CW'(e.data));
                    if (b2b_mode && e.idx > 0)
                        checkOutput("b2b_period", CW'(cyc - last_strobe), CW'(2));
                    last_strobe = cyc;
                    if (e.idx == N - 1) begin
                        ff_due   = cyc + 1 + S_EFF;
                        rdy_due  = ff_due + R_EFF;
                        ff_pend  = 1'b1;
                        rdy_pend = 1'b1;
                    end
                end
            end else if (prev_en != '0) begin
                checkOutput("data_hold", CW'(configs_in), CW'(prev_data));
            end
            if (ff_en && !prev_ff) begin
                if (ff_pend) checkOutput("ff_en_rise_cycle", CW'(cyc), CW'(ff_due));
                else failNow("unexpected_ff_en_rise");
                ff_pend = 1'b0;
            end
            if (rdy && !prev_rdy) begin
                if (rdy_pend) checkOutput("rdy_rise_cycle", CW'(cyc), CW'(rdy_due));
                else failNow("unexpected_rdy_rise");
                rdy_pend = 1'b0;
            end
        end
        prev_en   = configs_en;
        prev_data = configs_in;
        prev_ff   = ff_en;
        prev_rdy  = rdy;
    end

    always @(negedge clock) begin
        logic [BN-1:0] b_exp;
        if (!rst && b_en != '0) begin
            if (b_next >= BN) begin
                failNow("big_extra_strobe");
            end else begin
                b_exp = '0;
                b_exp[b_next] = 1'b1;
                checkOutput("big_strobe", CW'(b_en), CW'(b_exp));
                checkOutput("big_data", b_configs_in, b_words[b_next]);
                b_next++;
            end
        end
    end

    // Offer one word after a gap and hold it until the handshake edge has passed.
    task automatic applyStimulus(input logic [W-1:0] w, input int gap);
        bit got;
        if (gap > 0) begin
            cfg_valid = 1'b0;
            repeat (gap) tick();
        end
        cfg_valid = 1'b1;
        cfg_data  = w;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clock);
            if (cfg_ready) got = 1'b1;
        end
        if (!got) failNow("handshake_timeout");
        tick();
    endtask

    task automatic applyBig(input logic [BW-1:0] w, input int gap);
        bit got;
        if (gap > 0) begin
            b_valid = 1'b0;
            repeat (gap) tick();
        end
        b_valid = 1'b1;
        b_data  = w;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clock);
            if (b_ready) got = 1'b1;
        end
        if (!got) failNow("big_handshake_timeout");
        tick();
    endtask

    task automatic waitRdy();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clock);
            if (rdy) seen = 1'b1;
        end
        if (!seen) failNow("rdy_timeout");
        checkOutput("run_ff_en", CW'(ff_en), CW'(1));
        checkOutput("run_busy", CW'(busy), CW'(0));
        checkOutput("run_queue_empty", CW'(exp_q.size()), CW'(0));
    endtask

    task automatic loadConfig(input logic [W-1:0] words [N], input int gap_max,
                              input bit do_start, input bit settle_start);
        foreach (words[k]) exp_q.push_back('{k, words[k]});
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int k = 0; k < N; k++)
            applyStimulus(words[k], $urandom_range(gap_max, 0));
        cfg_valid = 1'b0;
        if (settle_start) begin
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        waitRdy();
    endtask

    task automatic randWords(output logic [W-1:0] words [N]);
        for (int k = 0; k < N; k++) words[k] = W'($urandom);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [W-1:0]  words [N];
        logic [BW-1:0] bw;
        bit            seen;

        // reset with valid already asserted, then idle
        cfg_valid = 1'b1;
        cfg_data  = 8'h5A;
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checkOutput("idle_outputs",
                        CW'({cfg_ready, configs_en, ff_en, rdy, busy, frame_idx, configs_in}), CW'(0));
        end
        checkOutput("big_idle", CW'({b_ready, b_en, b_ff_en, b_rdy, b_busy, b_idx}), CW'(0));
        cfg_valid = 1'b0;
        tick();

        // back-to-back load with fixed words
        words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3; words[3] = 8'hD4;
        b2b_mode = 1'b1;
        loadConfig(words, 0, 1'b1, 1'b0);
        b2b_mode = 1'b0;

        // random gaps (also reconfigures from RUN)
        for (int p = 0; p < 3; p++) begin
            randWords(words);
            loadConfig(words, 5, 1'b1, 1'b0);
        end

        // abort in LOAD after frame 1, with a word offered on the same cycle
        randWords(words);
        foreach (words[k]) exp_q.push_back('{k, words[k]});
        start = 1'b1;
        tick();
        start = 1'b0;
        applyStimulus(words[0], 0);
        applyStimulus(words[1], 0);
        tick();
        cfg_valid = 1'b1;
        cfg_data  = words[1] ^ 8'hFF;
        abort     = 1'b1;
        @(negedge clock);
        checkOutput("abort_ready_forced_low", CW'(cfg_ready), CW'(0));
        tick();
        abort     = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clock);
        checkOutput("abort_frame_idx", CW'(frame_idx), CW'(0));
        checkOutput("abort_busy", CW'(busy), CW'(0));
        checkOutput("abort_ready", CW'(cfg_ready), CW'(0));
        checkOutput("abort_en", CW'(configs_en), CW'(0));
        checkOutput("abort_data_kept", CW'(configs_in), CW'(words[1]));
        exp_q.delete();
        randWords(words);
        loadConfig(words, 2, 1'b1, 1'b0);

        // start in RUN drops ff_en/rdy at once; start during SETTLE is ignored
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clock);
        checkOutput("reconf_ff_en", CW'(ff_en), CW'(0));
        checkOutput("reconf_rdy", CW'(rdy), CW'(0));
        checkOutput("reconf_ready", CW'(cfg_ready), CW'(1));
        checkOutput("reconf_busy", CW'(busy), CW'(1));
        randWords(words);
        loadConfig(words, 3, 1'b0, 1'b1);

        // full-size load on the default-parameter instance
        for (int k = 0; k < BN; k++) begin
            for (int j = 0; j < BW / 32; j++) bw[j*32 +: 32] = $urandom;
            b_words[k] = bw;
        end
        tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < BN; k++) applyBig(b_words[k], $urandom_range(1, 0));
        b_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clock);
            if (b_rdy) seen = 1'b1;
        end
        if (!seen) failNow("big_rdy_timeout");
        checkOutput("big_strobe_count", CW'(b_next), CW'(BN));
        checkOutput("big_run", CW'({b_rdy, b_ff_en, b_busy}), CW'(3'b110));
        checkOutput("big_frame_idx", CW'(b_idx), CW'(0));

        checkOutput("scoreboard_empty", CW'(exp_q.size()), CW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
